// File: rtl/dbus_sram_responder_pkg.sv
// rtl/dbus_sram_responder_pkg.sv - shared dbus types, FSM states and helpers
package dbus_sram_responder_pkg;

   localparam int DBUS_WORD_BYTES = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WAIT  = 2'd1,
      RESP  = 2'd2,
      DRAIN = 2'd3
   } dbus_state_t;

   typedef struct packed {
      logic        valid;
      logic [63:0] addr;
      logic [2:0]  size;
      logic [7:0]  strobe;
      logic [63:0] data;
   } dbus_req_t;

   typedef struct packed {
      logic        addr_ok;
      logic        data_ok;
      logic [63:0] data;
   } dbus_resp_t;

   // Any asserted byte lane makes the access a store.
   function automatic logic dbus_is_write(input logic [7:0] strobe);
      return |strobe;
   endfunction

endpackage

// File: rtl/dbus_sram_responder_sram_be_bank.sv
// rtl/dbus_sram_responder_sram_be_bank.sv - 64-bit word SRAM, byte-enable write, registered read
module sram_be_bank #(
   parameter int DEPTH = 1024,
   parameter int IDX_W = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             we,
   input  logic [7:0]       be,
   input  logic [IDX_W-1:0] idx,
   input  logic [63:0]      wdata,
   output logic [63:0]      rdata
);

   logic [63:0] mem [DEPTH];
   logic [63:0] rdata_q;

   always_ff @(posedge clk) begin
      if (we) begin
         for (int i = 0; i < 8; i++) begin
            if (be[i]) begin
               mem[idx][8*i +: 8] <= wdata[8*i +: 8];
            end
         end
      end
      rdata_q <= mem[idx];
   end

   assign rdata = rdata_q;

endmodule

// File: rtl/dbus_sram_responder.sv
// rtl/dbus_sram_responder.sv - dbus responder: accepts a request, waits LATENCY cycles,
// then answers from / commits to a local byte-enabled SRAM window.
module dbus_sram_responder
   import dbus_sram_responder_pkg::*;
#(
   parameter int          DEPTH     = 1024,
   parameter int          LATENCY   = 2,
   parameter logic [63:0] BASE_ADDR = 64'h0
) (
   input  logic       clk,
   input  logic       rst_n,
   input  dbus_req_t  dreq,
   output dbus_resp_t dresp,
   output logic       oob_err,
   output logic       busy
);

   localparam int          IDX_W        = $clog2(DEPTH);
   localparam logic [63:0] WINDOW_BYTES = 64'(DEPTH) * 64'(DBUS_WORD_BYTES);
   localparam logic [3:0]  CNT_LOAD     = 4'(LATENCY - 1);

   dbus_state_t      state_q, state_d;
   logic [3:0]       cnt_q, cnt_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic [7:0]       strobe_q, strobe_d;
   logic [63:0]      wdata_q, wdata_d;
   logic             in_range_q, in_range_d;
   logic             oob_err_q, oob_err_d;

   logic [63:0]      req_off;
   logic             req_in_range;
   logic [IDX_W-1:0] req_idx;
   logic             accept;
   logic             bank_we;
   logic [IDX_W-1:0] bank_idx;
   logic [63:0]      bank_rdata;
   logic             unused_bits;

   // Offset compare avoids overflow of BASE_ADDR + window at the top of the address space.
   always_comb begin
      req_off      = dreq.addr - BASE_ADDR;
      req_in_range = (dreq.addr >= BASE_ADDR) && (req_off < WINDOW_BYTES);
      req_idx      = req_off[IDX_W+2:3];
   end

   assign accept      = rst_n && (state_q == IDLE) && dreq.valid;
   assign unused_bits = ^dreq.size;

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      idx_d      = idx_q;
      strobe_d   = strobe_q;
      wdata_d    = wdata_q;
      in_range_d = in_range_q;
      oob_err_d  = oob_err_q;
      case (state_q)
         IDLE: begin
            if (dreq.valid) begin
               idx_d      = req_idx;
               strobe_d   = dreq.strobe;
               wdata_d    = dreq.data;
               in_range_d = req_in_range;
               cnt_d      = CNT_LOAD;
               state_d    = (LATENCY == 1) ? RESP : WAIT;
            end
         end
         WAIT: begin
            cnt_d = cnt_q - 4'd1;
            if (cnt_q == 4'd1) begin
               state_d = RESP;
            end
         end
         RESP: begin
            state_d = DRAIN;
            if (!in_range_q) begin
               oob_err_d = 1'b1;
            end
         end
         DRAIN:   state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         cnt_q      <= 4'd0;
         idx_q      <= '0;
         strobe_q   <= 8'd0;
         wdata_q    <= 64'd0;
         in_range_q <= 1'b0;
         oob_err_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         idx_q      <= idx_d;
         strobe_q   <= strobe_d;
         wdata_q    <= wdata_d;
         in_range_q <= in_range_d;
         oob_err_q  <= oob_err_d;
      end
   end

   // The read is launched from the incoming address while IDLE so LATENCY=1 still has data in RESP.
   assign bank_idx = (state_q == IDLE) ? req_idx : idx_q;
   assign bank_we  = (state_q == RESP) && dbus_is_write(strobe_q) && in_range_q;

   sram_be_bank #(
      .DEPTH (DEPTH),
      .IDX_W (IDX_W)
   ) u_bank (
      .clk   (clk),
      .we    (bank_we),
      .be    (strobe_q),
      .idx   (bank_idx),
      .wdata (wdata_q),
      .rdata (bank_rdata)
   );

   always_comb begin
      dresp         = '0;
      dresp.addr_ok = accept;
      dresp.data_ok = (state_q == RESP);
      if ((state_q == RESP) && in_range_q && !dbus_is_write(strobe_q)) begin
         dresp.data = bank_rdata;
      end
   end

   assign oob_err = oob_err_q;
   assign busy    = (state_q != IDLE);

endmodule
